addr_region_decoder: RTL and testbench

ADDR_REGION_DECODER -- requirements
Module: addr_region_decoder

---
 rtl/addr_region_decoder.sv | 155 +++++++++++++++
 tb/tb_addr_region_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_region_decoder.sv
`default_nettype none
// ============================================================================
// Module : addr_region_decoder
// Brief  : Programmable address-map lookup with lowest-index priority,
//          lockable rule table, registered one-cycle result and miss counter.
// Rev    : 1.0
// ============================================================================
module addr_region_decoder #(
  parameter int NumRules  = 9,
  parameter int AddrWidth = 64,
  parameter logic [NumRules-1:0][AddrWidth-1:0] DefaultBase = {
    64'h0000_0000_8000_0000,  // DRAM
    64'h0000_0000_3000_0000,  // Ethernet
    64'h0000_0000_2000_0000,  // SPI
    64'h0000_0000_1000_0000,  // UART
    64'h0000_0000_0C00_0000,  // PLIC
    64'h0000_0000_0200_0000,  // CLINT
    64'h0000_0000_0010_0000,  // GPIO
    64'h0000_0000_0001_0000,  // ROM
    64'h0000_0000_0000_0000   // Debug
  },
  parameter logic [NumRules-1:0][AddrWidth-1:0] DefaultLength = {
    64'h0000_0000_4000_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0080_0000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_03FF_FFFF,
    64'h0000_0000_000C_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0000_1000
  },
  parameter logic [NumRules-1:0][2:0] DefaultAttr = {
    3'b111, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b101
  },
  parameter int IdxWidth = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  output logic                 locked_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxWidth-1:0]  resp_idx_o,
  output logic [2:0]           resp_attr_o,
  output logic [15:0]          miss_cnt_o
);

  logic [AddrWidth-1:0] r_base [NumRules];
  logic [AddrWidth-1:0] r_len  [NumRules];
  logic [2:0]           r_attr [NumRules];

  logic                 r_locked;
  logic                 r_cfg_err;
  logic                 r_resp_valid;
  logic                 r_resp_hit;
  logic [IdxWidth-1:0]  r_resp_idx;
  logic [2:0]           r_resp_attr;
  logic [15:0]          r_miss_cnt;

  logic [NumRules-1:0]  w_match;
  logic                 w_hit;
  logic [IdxWidth-1:0]  w_idx;
  logic [2:0]           w_attr;
  logic                 w_idx_ok;
  logic                 w_cfg_wr;
  logic                 w_req_fire;

  // Region end is formed one bit wider so a rule near the top never wraps to 0.
  for (genvar gi = 0; gi < NumRules; gi++) begin : g_match
    logic [AddrWidth:0] w_end;
    assign w_end       = {1'b0, r_base[gi]} + {1'b0, r_len[gi]};
    assign w_match[gi] = (r_len[gi] != '0) &&
                         (req_addr_i >= r_base[gi]) &&
                         ({1'b0, req_addr_i} < w_end);
  end

  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_attr = '0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_idx  = IdxWidth'(i);
        w_attr = r_attr[i];
      end
    end
  end

  assign w_idx_ok    = (32'(cfg_idx_i) < 32'(NumRules));
  assign w_cfg_wr    = cfg_we_i && !r_locked && w_idx_ok;
  assign req_ready_o = !r_resp_valid || resp_ready_i;
  assign w_req_fire  = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRules; i++) begin
        r_base[i] <= DefaultBase[i];
        r_len[i]  <= DefaultLength[i];
        r_attr[i] <= DefaultAttr[i];
      end
      r_locked     <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_idx   <= '0;
      r_resp_attr  <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_cfg_err <= cfg_we_i && !w_cfg_wr;
      for (int i = 0; i < NumRules; i++) begin
        if (w_cfg_wr && (cfg_idx_i == IdxWidth'(i))) begin
          r_base[i] <= cfg_base_i;
          r_len[i]  <= cfg_len_i;
          r_attr[i] <= cfg_attr_i;
        end
      end
      if (cfg_lock_i) begin
        r_locked <= 1'b1;
      end
      if (w_req_fire) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= w_hit;
        r_resp_idx   <= w_idx;
        r_resp_attr  <= w_attr;
        if (!w_hit && (r_miss_cnt != 16'hFFFF)) begin
          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end else if (resp_ready_i) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign cfg_err_o    = r_cfg_err;
  assign locked_o     = r_locked;
  assign resp_valid_o = r_resp_valid;
  assign resp_hit_o   = r_resp_hit;
  assign resp_idx_o   = r_resp_idx;
  assign resp_attr_o  = r_resp_attr;
  assign miss_cnt_o   = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_addr_region_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_addr_region_decoder
// Brief  : Directed and random checks of addr_region_decoder against a
//          behavioural address-map model.
// Rev    : 1.0
// ============================================================================
module tb_addr_region_decoder;

  localparam int N  = 9;
  localparam int AW = 64;
  localparam int IW = 4;

  localparam logic [63:0] c_def_base [N] = '{
    64'h0, 64'h1_0000, 64'h10_0000, 64'h200_0000, 64'hC00_0000,
    64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h8000_0000};
  localparam logic [63:0] c_def_len [N] = '{
    64'h1000, 64'h1_0000, 64'h1_0000, 64'hC_0000, 64'h3FF_FFFF,
    64'h1000, 64'h80_0000, 64'h1_0000, 64'h4000_0000};
  localparam logic [2:0] c_def_attr [N] = '{
    3'b101, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b111};

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len;
  logic [2:0]    cfg_attr;
  logic          cfg_lock;
  logic          cfg_err;
  logic          locked;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic [IW-1:0] resp_idx;
  logic [2:0]    resp_attr;
  logic [15:0]   miss_cnt;

  always #5 clk = ~clk;

  addr_region_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_base_i   (cfg_base),
    .cfg_len_i    (cfg_len),
    .cfg_attr_i   (cfg_attr),
    .cfg_lock_i   (cfg_lock),
    .cfg_err_o    (cfg_err),
    .locked_o     (locked),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_hit_o   (resp_hit),
    .resp_idx_o   (resp_idx),
    .resp_attr_o  (resp_attr),
    .miss_cnt_o   (miss_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the rule table plus what the result register should hold.
  logic [63:0] m_base [N];
  logic [63:0] m_len  [N];
  logic [2:0]  m_attr [N];
  logic        m_locked, m_err, m_valid, m_hit;
  logic [3:0]  m_idx;
  logic [2:0]  m_attr_o;
  int          m_miss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_base[i] = c_def_base[i];
      m_len[i]  = c_def_len[i];
      m_attr[i] = c_def_attr[i];
    end
    m_locked = 1'b0; m_err = 1'b0; m_valid = 1'b0;
    m_hit = 1'b0; m_idx = '0; m_attr_o = '0; m_miss = 0;
  endtask

  task automatic model_lookup(input logic [63:0] a, output logic h,
                              output logic [3:0] ix, output logic [2:0] at);
    h = 1'b0; ix = '0; at = '0;
    for (int i = 0; i < N; i++) begin
      if (!h && m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
        h = 1'b1; ix = 4'(i); at = m_attr[i];
      end
    end
  endtask

  task automatic model_step();
    logic h, rdy, bad;
    logic [3:0] ix;
    logic [2:0] at;
    rdy = !m_valid || resp_ready;
    model_lookup(req_addr, h, ix, at);
    bad = cfg_we && (m_locked || int'(cfg_idx) >= N);
    if (req_valid && rdy) begin
      m_valid = 1'b1; m_hit = h; m_idx = ix; m_attr_o = at;
      if (!h && m_miss < 65535) m_miss++;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    m_err = bad;
    if (cfg_we && !bad) begin
      m_base[cfg_idx] = cfg_base;
      m_len[cfg_idx]  = cfg_len;
      m_attr[cfg_idx] = cfg_attr;
    end
    if (cfg_lock) m_locked = 1'b1;
  endtask

  task automatic check_outputs();
    check("resp_valid", resp_valid, m_valid);
    check("req_ready",  req_ready,  !m_valid || resp_ready);
    check("cfg_err",    cfg_err,    m_err);
    check("locked",     locked,     m_locked);
    check("miss_cnt",   miss_cnt,   64'(m_miss));
    if (m_valid) begin
      check("resp_hit",  resp_hit,  m_hit);
      check("resp_idx",  resp_idx,  m_idx);
      check("resp_attr", resp_attr, m_attr_o);
    end
  endtask

  task automatic step(input logic rv, input logic [63:0] a, input logic rr,
                      input logic we, input logic [3:0] ix, input logic [63:0] b,
                      input logic [63:0] l, input logic [2:0] at, input logic lk);
    req_valid = rv; req_addr = a; resp_ready = rr;
    cfg_we = we; cfg_idx = ix; cfg_base = b; cfg_len = l; cfg_attr = at; cfg_lock = lk;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic lookup(input logic [63:0] a);
    step(1'b1, a, 1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 3'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] ix, input logic [63:0] b, input logic [63:0] l,
                    input logic [2:0] at);
    step(1'b0, 64'd0, 1'b1, 1'b1, ix, b, l, at, 1'b0);
  endtask

  // Reset is applied with live cfg/req traffic to show it wins.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_addr = {$urandom, $urandom}; resp_ready = 1'($urandom);
    cfg_we = 1'b1; cfg_idx = 4'($urandom); cfg_base = {$urandom, $urandom};
    cfg_len = {$urandom, $urandom}; cfg_attr = 3'($urandom); cfg_lock = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", req_ready, 1'b1);
    check("valid_in_reset", resp_valid, 1'b0);
    model_reset();
    rst = 1'b0;
    req_valid = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0; resp_ready = 1'b1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_attr = '0; cfg_lock = 1'b0;
    model_reset();
    do_reset();
    check("rst_miss", miss_cnt, 0);
    check("rst_locked", locked, 0);

    // DRAM edges and first miss
    lookup(64'h8000_0000);
    check("dram_lo_hit", resp_hit, 1); check("dram_lo_idx", resp_idx, 8); check("dram_lo_attr", resp_attr, 3'b111);
    lookup(64'hBFFF_FFFF);
    check("dram_hi_hit", resp_hit, 1); check("dram_hi_idx", resp_idx, 8);
    lookup(64'hC000_0000);
    check("dram_end_hit", resp_hit, 0); check("dram_end_idx", resp_idx, 0);
    check("dram_end_attr", resp_attr, 0); check("dram_end_miss", miss_cnt, 1);

    // Debug region boundary
    lookup(64'h0FFF);
    check("dbg_hit", resp_hit, 1); check("dbg_idx", resp_idx, 0); check("dbg_attr", resp_attr, 3'b101);
    lookup(64'h1000);
    check("dbg_end_hit", resp_hit, 0);

    // Overlap: lowest index wins
    wr(4'd2, 64'h0, 64'h2000, 3'b001);
    lookup(64'h800);
    check("prio_idx", resp_idx, 0); check("prio_attr", resp_attr, 3'b101);
    lookup(64'h1800);
    check("ovl_idx", resp_idx, 2);

    // Same-cycle lookup and write sees the old table
    step(1'b1, 64'h10_0000, 1'b1, 1'b1, 4'd2, 64'h10_0000, 64'h1_0000, 3'b001, 1'b0);
    check("wr_same_cycle_hit", resp_hit, 0);
    lookup(64'h10_0000);
    check("wr_after_hit", resp_hit, 1); check("wr_after_idx", resp_idx, 2);

    // Lock, then rejected writes
    step(1'b0, 64'd0, 1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 3'd0, 1'b1);
    check("lock_set", locked, 1);
    wr(4'd0, 64'h5000_0000, 64'h1000, 3'b000);
    check("lock_err", cfg_err, 1);
    idle();
    check("lock_err_pulse", cfg_err, 0);
    lookup(64'h0);
    check("lock_keep_idx", resp_idx, 0); check("lock_keep_attr", resp_attr, 3'b101);
    lookup(64'h5000_0000);
    check("lock_keep_miss", resp_hit, 0);
    check("lock_sticky", locked, 1);
    do_reset();
    wr(4'(31), 64'h0, 64'h1000, 3'b000);
    check("bad_idx_err", cfg_err, 1);
    idle();
    check("bad_idx_pulse", cfg_err, 0);

    // Backpressure then back-to-back results
    step(1'b1, 64'h1_0000, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 3'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 64'h8000_0000, 1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 3'd0, 1'b0);
      check("hold_ready", req_ready, 0); check("hold_valid", resp_valid, 1);
      check("hold_idx", resp_idx, 1); check("hold_attr", resp_attr, 3'b101);
    end
    lookup(64'h8000_0000); check("b2b_0", resp_idx, 8);
    lookup(64'h0);         check("b2b_1", resp_idx, 0);
    lookup(64'h1000_0000); check("b2b_2", resp_idx, 5);
    idle();
    check("drain_valid", resp_valid, 0);

    // Top-of-space rule must not wrap, then saturate the miss counter
    do_reset();
    wr(4'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001);
    lookup(64'h0);
    check("nowrap_hit", resp_hit, 0);
    lookup(64'hFFFF_FFFF_FFFF_FFFF);
    check("top_hit", resp_hit, 1); check("top_idx", resp_idx, 0);
    req_valid = 1'b1; req_addr = 64'h0; resp_ready = 1'b1; cfg_we = 1'b0; cfg_lock = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      model_step();
      @(posedge clk);
    end
    @(negedge clk);
    check_outputs();
    check("miss_sat", miss_cnt, 16'hFFFF);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        int r;
        logic [63:0] a;
        r = int'($urandom_range(N - 1));
        case ($urandom_range(3))
          0: a = m_base[r];
          1: a = m_base[r] + m_len[r] - 64'd1;
          2: a = m_base[r] + m_len[r];
          default: a = {$urandom, $urandom};
        endcase
        step(1'($urandom), a, ($urandom_range(3) != 0),
             ($urandom_range(7) == 0), 4'($urandom),
             64'($urandom_range(15)) << 28,
             64'($urandom_range(4)) << $urandom_range(28, 12),
             3'($urandom), ($urandom_range(199) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
